// File: rtl/ws2812_pkg.sv
// ============================================================================
// Module : ws2812_pkg
// Shared state encoding, 12 MHz default timing and bit-timing helper for the
// WS2812 stream driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int DEF_NUM_LEDS = 64;
  localparam int DEF_BPP      = 24;
  localparam int DEF_TBIT_CYC = 15;
  localparam int DEF_T0H_CYC  = 5;
  localparam int DEF_T1H_CYC  = 10;
  localparam int DEF_TRST_CYC = 3600;

  function automatic int bit_high_cyc(input logic bit_val, input int t0h, input int t1h);
    return bit_val ? t1h : t0h;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_bit_timer.sv
// ============================================================================
// Module : ws2812_bit_timer
// Generates the high/low waveform of one WS2812 bit period and flags its
// final cycle so the parent can chain the next bit without a gap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ws2812_bit_timer
  import ws2812_pkg::*;
#(
  parameter int TBIT_CYC = DEF_TBIT_CYC,
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic bit_val_i,
  output logic line_o,
  output logic last_cycle_o
);

  localparam int              CW       = (TBIT_CYC > 1) ? $clog2(TBIT_CYC) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(TBIT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          val_q, val_d;
  logic          line_q, line_d;

  always_comb begin
    cnt_d  = cnt_q;
    run_d  = run_q;
    val_d  = val_q;
    line_d = line_q;
    if (start_i) begin
      cnt_d  = '0;
      val_d  = bit_val_i;
      run_d  = 1'b1;
      line_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d  = '0;
        run_d  = 1'b0;
        line_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        // Level for the upcoming cycle, so the line stays a pure register.
        line_d = ((int'(cnt_q) + 1) < bit_high_cyc(val_q, T0H_CYC, T1H_CYC));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      val_q  <= 1'b0;
      line_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      val_q  <= val_d;
      line_q <= line_d;
    end
  end

  assign line_o       = line_q;
  assign last_cycle_o = run_q && (cnt_q == LAST_CNT);

endmodule

`default_nettype wire

// File: rtl/ws2812_stream_driver.sv
// ============================================================================
// Module : ws2812_stream_driver
// Streams pixels from a valid/ready interface onto a WS2812 data line with a
// one-entry prefetch buffer, end-of-frame latch gap and sticky underrun flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ws2812_stream_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int BPP      = DEF_BPP,
  parameter int TBIT_CYC = DEF_TBIT_CYC,
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC,
  parameter int TRST_CYC = DEF_TRST_CYC
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_start_i,
  input  logic [BPP-1:0] pixel_data_i,
  input  logic           pixel_valid_i,
  output logic           pixel_ready_o,
  output logic           busy_o,
  output logic           frame_done_o,
  output logic           underrun_o,
  output logic           dout_o
);

  localparam int MAX_CYC = (TBIT_CYC > TRST_CYC) ? TBIT_CYC : TRST_CYC;
  localparam int CW      = $clog2(MAX_CYC);
  localparam int BW      = $clog2(BPP);
  localparam int PW      = $clog2(NUM_LEDS + 1);

  localparam logic [BW-1:0] LAST_BIT  = BW'(BPP - 1);
  localparam logic [PW-1:0] NUM_PIX   = PW'(NUM_LEDS);
  localparam logic [CW-1:0] LAT_LAST  = CW'(TRST_CYC - 1);
  localparam logic [CW-1:0] LAT_PULSE = CW'(TRST_CYC - 2);

  if (!(BPP == 24 || BPP == 32)) begin : g_bad_bpp
    $error("ws2812_stream_driver: BPP must be 24 or 32");
  end
  if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC && TRST_CYC >= 2 && NUM_LEDS >= 1))
  begin : g_bad_timing
    $error("ws2812_stream_driver: illegal timing or size parameters");
  end

  state_t         state_q, state_d;
  logic [BPP-1:0] shift_q, shift_d;
  logic [BPP-1:0] buf_q, buf_d;
  logic           buf_full_q, buf_full_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]  lat_cnt_q, lat_cnt_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           underrun_q, underrun_d;

  logic w_hs;
  logic w_start;
  logic w_bit_val;
  logic w_last;
  logic w_line;

  assign w_hs = pixel_valid_i && ready_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    bit_cnt_d  = bit_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    w_start    = 1'b0;
    w_bit_val  = shift_q[BPP-1];

    unique case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          state_d    = FIRST;
          busy_d     = 1'b1;
          underrun_d = 1'b0;
          pix_cnt_d  = '0;
          buf_full_d = 1'b0;
        end
      end
      FIRST: begin
        if (w_hs) begin
          shift_d   = pixel_data_i;
          bit_cnt_d = '0;
          pix_cnt_d = pix_cnt_q + 1'b1;
          w_start   = 1'b1;
          w_bit_val = pixel_data_i[BPP-1];
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (w_hs) begin
          buf_d      = pixel_data_i;
          buf_full_d = 1'b1;
        end
        if (w_last) begin
          if (bit_cnt_q != LAST_BIT) begin
            shift_d   = {shift_q[BPP-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
            w_start   = 1'b1;
            w_bit_val = shift_q[BPP-2];
          end else if (pix_cnt_q == NUM_PIX) begin
            state_d   = LATCH;
            lat_cnt_d = '0;
          end else if (buf_full_q) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            bit_cnt_d  = '0;
            pix_cnt_d  = pix_cnt_q + 1'b1;
            w_start    = 1'b1;
            w_bit_val  = buf_q[BPP-1];
          end else if (w_hs) begin
            // Pixel arrived exactly at the boundary: skip the buffer.
            shift_d    = pixel_data_i;
            buf_full_d = 1'b0;
            bit_cnt_d  = '0;
            pix_cnt_d  = pix_cnt_q + 1'b1;
            w_start    = 1'b1;
            w_bit_val  = pixel_data_i[BPP-1];
          end else begin
            underrun_d = 1'b1;
            state_d    = LATCH;
            lat_cnt_d  = '0;
          end
        end
      end
      LATCH: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (lat_cnt_q == LAT_PULSE) begin
          done_d = 1'b1;
        end
        if (lat_cnt_q == LAT_LAST) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          lat_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == FIRST) ||
              ((state_d == SHIFT) && !buf_full_d && (pix_cnt_d < NUM_PIX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      bit_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      lat_cnt_q  <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      bit_cnt_q  <= bit_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  ws2812_bit_timer #(
    .TBIT_CYC (TBIT_CYC),
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC)
  ) u_bit_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (w_start),
    .bit_val_i    (w_bit_val),
    .line_o       (w_line),
    .last_cycle_o (w_last)
  );

  assign pixel_ready_o = ready_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = done_q;
  assign underrun_o    = underrun_q;
  assign dout_o        = w_line;

endmodule

`default_nettype wire
